// File: rtl/zsy_oled_sequencer.sv
// SSD1306 128x64 OLED sequencer: panel reset, init command list and full-frame
// streaming through a single-byte SPI transmitter with an en/is_done handshake.
module zsy_oled_sequencer #(
  parameter int unsigned RST_LOW_CYCLES  = 1000,
  parameter int unsigned RST_WAIT_CYCLES = 1000,
  parameter int unsigned N_PAGES         = 8,
  parameter int unsigned N_COLS          = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       reinit,
  output logic       busy,
  output logic       done,
  output logic       oled_rst_n,
  output logic       spi_en,
  output logic [7:0] spi_tx_byte,
  output logic       spi_dc_flag,
  input  logic       spi_is_done,
  output logic [9:0] fb_addr,
  input  logic [7:0] fb_data
);

  localparam int unsigned CNT_MAX  = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES
                                                                        : RST_WAIT_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned INIT_LEN = 25;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned PAGE_W   = 3;
  localparam int unsigned COL_W    = 7;

  localparam logic [CNT_W-1:0]  LOW_LAST  = CNT_W'(RST_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(RST_WAIT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  INIT_LAST = IDX_W'(INIT_LEN - 1);
  localparam logic [IDX_W-1:0]  PCMD_LAST = IDX_W'(2);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(N_PAGES - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(N_COLS - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RST_LOW  = 4'd1,
    RST_WAIT = 4'd2,
    INIT_CMD = 4'd3,
    PAGE_CMD = 4'd4,
    FB_READ  = 4'd5,
    DATA     = 4'd6,
    GAP      = 4'd7,
    FINISH   = 4'd8
  } state_t;

  state_t state, state_d;
  state_t ret, ret_d;

  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [PAGE_W-1:0] page, page_d;
  logic [COL_W-1:0]  col, col_d;
  logic              inited, inited_d;

  logic       busy_d, done_d, oled_rst_n_d, spi_en_d, spi_dc_flag_d;
  logic [7:0] spi_tx_byte_d;
  logic [9:0] fb_addr_d;

  logic xfer_done_c;
  logic last_byte_c;

  assign xfer_done_c = spi_en & spi_is_done;
  assign last_byte_c = (page == PAGE_LAST) && (col == COL_LAST);

  // Panel power-up command list, sent once after each panel reset
  function automatic logic [7:0] init_byte(input logic [IDX_W-1:0] i);
    logic [7:0] b;
    case (i)
      5'd0:    b = 8'hAE;
      5'd1:    b = 8'hD5;
      5'd2:    b = 8'h80;
      5'd3:    b = 8'hA8;
      5'd4:    b = 8'h3F;
      5'd5:    b = 8'hD3;
      5'd6:    b = 8'h00;
      5'd7:    b = 8'h40;
      5'd8:    b = 8'h8D;
      5'd9:    b = 8'h14;
      5'd10:   b = 8'h20;
      5'd11:   b = 8'h02;
      5'd12:   b = 8'hA1;
      5'd13:   b = 8'hC8;
      5'd14:   b = 8'hDA;
      5'd15:   b = 8'h12;
      5'd16:   b = 8'h81;
      5'd17:   b = 8'hCF;
      5'd18:   b = 8'hD9;
      5'd19:   b = 8'hF1;
      5'd20:   b = 8'hDB;
      5'd21:   b = 8'h40;
      5'd22:   b = 8'hA4;
      5'd23:   b = 8'hA6;
      default: b = 8'hAF;
    endcase
    return b;
  endfunction

  // Page address command bytes: page start, column low nibble, column high nibble
  function automatic logic [7:0] page_byte(input logic [IDX_W-1:0] i, input logic [PAGE_W-1:0] p);
    logic [7:0] b;
    case (i)
      5'd0:    b = 8'hB0 | {5'd0, p};
      5'd1:    b = 8'h00;
      default: b = 8'h10;
    endcase
    return b;
  endfunction

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ret         <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      page        <= '0;
      col         <= '0;
      inited      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      oled_rst_n  <= 1'b0;
      spi_en      <= 1'b0;
      spi_tx_byte <= 8'h00;
      spi_dc_flag <= 1'b0;
      fb_addr     <= '0;
    end else begin
      state       <= state_d;
      ret         <= ret_d;
      cnt         <= cnt_d;
      idx         <= idx_d;
      page        <= page_d;
      col         <= col_d;
      inited      <= inited_d;
      busy        <= busy_d;
      done        <= done_d;
      oled_rst_n  <= oled_rst_n_d;
      spi_en      <= spi_en_d;
      spi_tx_byte <= spi_tx_byte_d;
      spi_dc_flag <= spi_dc_flag_d;
      fb_addr     <= fb_addr_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (start) state_d = (!inited || reinit) ? RST_LOW : PAGE_CMD;
      RST_LOW:  if (cnt == LOW_LAST) state_d = RST_WAIT;
      RST_WAIT: if (cnt == WAIT_LAST) state_d = INIT_CMD;
      INIT_CMD: if (xfer_done_c) state_d = GAP;
      PAGE_CMD: if (xfer_done_c) state_d = GAP;
      FB_READ:  state_d = DATA;
      DATA:     if (xfer_done_c) state_d = last_byte_c ? FINISH : GAP;
      GAP:      state_d = ret;
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values for counters and registered outputs
  always_comb begin
    ret_d         = ret;
    cnt_d         = cnt;
    idx_d         = idx;
    page_d        = page;
    col_d         = col;
    inited_d      = inited;
    busy_d        = busy;
    done_d        = 1'b0;
    oled_rst_n_d  = oled_rst_n;
    spi_en_d      = spi_en;
    spi_tx_byte_d = spi_tx_byte;
    spi_dc_flag_d = spi_dc_flag;
    fb_addr_d     = fb_addr;
    case (state)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (!inited || reinit) begin
            oled_rst_n_d = 1'b0;
            cnt_d        = '0;
          end else begin
            page_d = '0;
            idx_d  = '0;
          end
        end
      end
      RST_LOW: begin
        if (cnt == LOW_LAST) begin
          oled_rst_n_d = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RST_WAIT: begin
        if (cnt == WAIT_LAST) begin
          cnt_d = '0;
          idx_d = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      INIT_CMD: begin
        if (!spi_en) begin
          spi_en_d      = 1'b1;
          spi_tx_byte_d = init_byte(idx);
          spi_dc_flag_d = 1'b0;
        end else if (spi_is_done) begin
          spi_en_d = 1'b0;
          if (idx == INIT_LAST) begin
            inited_d = 1'b1;
            idx_d    = '0;
            page_d   = '0;
            ret_d    = PAGE_CMD;
          end else begin
            idx_d = idx + IDX_W'(1);
            ret_d = INIT_CMD;
          end
        end
      end
      PAGE_CMD: begin
        if (!spi_en) begin
          spi_en_d      = 1'b1;
          spi_tx_byte_d = page_byte(idx, page);
          spi_dc_flag_d = 1'b0;
        end else if (spi_is_done) begin
          spi_en_d = 1'b0;
          if (idx == PCMD_LAST) begin
            idx_d = '0;
            col_d = '0;
            ret_d = FB_READ;
          end else begin
            idx_d = idx + IDX_W'(1);
            ret_d = PAGE_CMD;
          end
        end
      end
      GAP: begin
        if (ret == FB_READ) fb_addr_d = {page, col};
      end
      DATA: begin
        if (!spi_en) begin
          spi_en_d      = 1'b1;
          spi_tx_byte_d = fb_data;
          spi_dc_flag_d = 1'b1;
        end else if (spi_is_done) begin
          spi_en_d = 1'b0;
          if (last_byte_c) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else if (col != COL_LAST) begin
            col_d = col + COL_W'(1);
            ret_d = FB_READ;
          end else begin
            page_d = page + PAGE_W'(1);
            idx_d  = '0;
            ret_d  = PAGE_CMD;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
